// File: rtl/seq_bit_serializer_pkg.sv
// seq_bit_serializer_pkg: shared state encoding and idle-level constant for the serializer
package seq_bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Idle level held on the serial line between words; high so idle time cannot start a pattern
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial shifter with a one-word holding buffer for gapless streaming
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter logic IDLE_BIT  = IDLE_LEVEL,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);

    ser_state_t       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;
    logic             free;
    logic             cur_bit;

    // Outputs decode from registers only, so nothing combinational reaches them from din or din_valid
    assign cur_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign din_ready  = !hold_full;
    assign ser_active = (state == SHIFT);
    assign ser_out    = (state == SHIFT) ? cur_bit : IDLE_BIT;
    assign word_done  = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));
    assign accept     = din_valid && din_ready;
    assign free       = (state == IDLE) || word_done;

    // Shifter/hold-buffer sequencing: a held word always wins the reload, otherwise load din directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (free) begin
            if (hold_full) begin
                shreg     <= hold;
                hold_full <= 1'b0;
                state     <= SHIFT;
                bit_cnt   <= '0;
            end else if (accept) begin
                shreg   <= din;
                state   <= SHIFT;
                bit_cnt <= '0;
            end else begin
                state <= IDLE;
            end
        end else begin
            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
            shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: randomized and directed checks of both bit orders against a bit-queue model
module tb_seq_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         m_ready, m_ser, m_act, m_done;
    logic         l_ready, l_ser, l_act, l_done;
    int           passed = 0;
    int           total = 0;
    logic [1:0]   qm[$];
    logic [1:0]   ql[$];
    logic [23:0]  cap;

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .ser_out(m_ser), .ser_active(m_act), .word_done(m_done)
    );

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .ser_out(l_ser), .ser_active(l_act), .word_done(l_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: the line is a FIFO of {last, bit}; one entry leaves per clock, an accepted word appends W entries.
    // More than W queued entries means a whole word waits behind the current one, i.e. the hold buffer is full.
    always @(posedge clk or negedge reset) begin : model
        bit acc;
        if (!reset) begin
            qm.delete();
            ql.delete();
        end else begin
            acc = din_valid && (qm.size() <= W);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc)
                for (int i = 0; i < W; i++) begin
                    qm.push_back({i == W - 1, din[W-1-i]});
                    ql.push_back({i == W - 1, din[i]});
                end
        end
    end

    always @(negedge clk) begin
        check("m_ser",   m_ser,   qm.size() > 0 ? qm[0][0] : 1'b1);
        check("m_act",   m_act,   qm.size() > 0);
        check("m_done",  m_done,  qm.size() > 0 && qm[0][1]);
        check("m_ready", m_ready, qm.size() <= W);
        check("l_ser",   l_ser,   ql.size() > 0 ? ql[0][0] : 1'b1);
        check("l_act",   l_act,   ql.size() > 0);
        check("l_done",  l_done,  ql.size() > 0 && ql[0][1]);
        check("l_ready", l_ready, ql.size() <= W);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_ser", m_ser, 1'b1);
            check("rst_act", m_act, 1'b0);
            check("rst_ready", m_ready, 1'b1);
            check("rst_done", m_done, 1'b0);
        end
        din = 8'h6A;
        din_valid = 1'b1;
        cap = '0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) din_valid = 1'b0;
            if (i <= 8) cap = {cap[22:0], m_ser};
            check("single_done", m_done, i == 8);
            if (i == 9) check("single_idle", m_ser, 1'b1);
        end
        check("single_bits", cap[7:0], 8'h6A);
        repeat (2) @(negedge clk);
        din = 8'h01;
        din_valid = 1'b1;
        cap = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) din_valid = 1'b0;
            cap = {cap[22:0], l_ser};
        end
        check("lsb_bits", cap[7:0], 8'h80);
        repeat (3) @(negedge clk);
        din = 8'hA5;
        din_valid = 1'b1;
        cap = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i <= 24) cap = {cap[22:0], m_ser};
            check("b2b_done", m_done, i == 8 || i == 16 || i == 24);
            if (i >= 2 && i <= 17) check("b2b_ready", m_ready, i == 9 || i == 17);
            if (i <= 24) check("b2b_active", m_act, 1'b1);
            if (i == 25) check("b2b_idle", m_act, 1'b0);
            if (i == 1) din = 8'h3C;
            if (i == 2) din = 8'h96;
            if (i == 10) din_valid = 1'b0;
        end
        check("b2b_bits", cap, 24'hA53C96);
        repeat (2) @(negedge clk);
        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h5A;
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_ser", m_ser, 1'b1);
        check("midrst_act", m_act, 1'b0);
        check("midrst_ready", m_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("postrst_act", m_act, 1'b0);
            check("postrst_ser", m_ser, 1'b1);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!(din_valid && !m_ready)) begin
                din = W'($urandom);
                din_valid = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("drain_act", m_act, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Upstream feeder for the serial sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, which connects directly to the detector's serial input. A one-word holding buffer lets back-to-back words stream with no idle gap. Between words the line is driven to a fixed idle level chosen so that idle time cannot start a pattern.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range is WIDTH >= 2.
- IDLE_BIT, 1'b1, level driven on ser_out while no word is shifting.
- MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream to the detector.
- ser_active  output  1  ser_out carries a data bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on ser_out.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, bit_cnt=0, hold buffer empty, shift register cleared.
  - Outputs during and immediately after reset: ser_out=IDLE_BIT, ser_active=0, word_done=0, din_ready=1.
- State register: IDLE or SHIFT.
- bit_cnt: $clog2(WIDTH) bits wide; counts 0..WIDTH-1 in SHIFT.
- Output decoding (from registers only, no combinational path from din or din_valid):
  - din_ready = !hold_full.
  - ser_out = (state==SHIFT) ? current bit of shift register : IDLE_BIT.
  - ser_active = (state==SHIFT).
  - word_done = (state==SHIFT && bit_cnt==WIDTH-1).
- Handshake: a word is accepted on a rising edge where din_valid && din_ready. din is ignored at all other times.
- Define free = (state==IDLE) || word_done. This means the shifter can take a new word at this edge.
- Per-edge priority:
  1. free && hold_full: load shifter from the hold buffer; hold becomes empty; state=SHIFT; bit_cnt=0. No accept is possible this edge because din_ready=0.
  2. free && !hold_full && accept: load shifter directly from din; state=SHIFT; bit_cnt=0.
  3. free && nothing to load: state=IDLE.
  4. !free && accept: din goes into the hold buffer; hold becomes full.
  5. In SHIFT and not the last bit: shift by one position in the direction set by MSB_FIRST; bit_cnt+1.
- Latency: a word accepted at edge k puts its first bit on ser_out in the cycle after edge k. Bit i appears in cycle k+1+i.
- Throughput: one bit per clock. Words accepted back to back give contiguous bits with no IDLE cycle between them. ser_active stays high and word_done pulses once every WIDTH cycles.
- Hold buffer:
  - Full: din_ready=0 until the shifter reloads from the hold buffer; din_ready returns to 1 the cycle after that reload.
  - Empty: at most one word is buffered beyond the one shifting.
- din_valid held high while din_ready=0: no accept and no state change from din. The upstream source must hold din stable.
- Wrap-around: bit_cnt returns to 0 on every load, never by overflow.
- Reset asserted mid-word: the shifting word and any held word are discarded. ser_out returns to IDLE_BIT asynchronously. No partial-word completion after reset is released.

Decomposition:
- Shared package/include: state encodings IDLE=1'b0 and SHIFT=1'b1, and the default idle-level constant.
- Single module. The hold buffer and shifter are small enough that no sub-module is warranted.

Test Plan:
- Reset check: hold reset low, then release with din_valid=0 -> ser_out=1, ser_active=0, din_ready=1, word_done=0 for 20 cycles.
- Single word, WIDTH=8, MSB_FIRST=1: din=8'h6A accepted at edge k ->
  - ser_out=0,1,1,0,1,0,1,0 in cycles k+1..k+8;
  - word_done only in cycle k+8;
  - ser_out=1 from cycle k+9.
- Back-to-back: 8'hA5 accepted at edge k, 8'h3C accepted at edge k+1 ->
  - din_ready=0 in cycles k+2..k+8;
  - 16 contiguous bits 10100101 00111100;
  - ser_active high for 16 cycles;
  - word_done in cycles k+8 and k+16.
- Backpressure: din_valid held high with a third word while hold is full -> word is not accepted until din_ready=1, then streams after the second word with no gap and no loss.
- MSB_FIRST=0: din=8'h01 -> ser_out=1,0,0,0,0,0,0,0.
- Reset mid-word: assert reset after the 3rd bit of 8'hFF with a word in hold -> ser_out=1 and ser_active=0 immediately; after release no further data bits appear until a new accept.
